// File: rtl/lipsi_pin_host_pkg.sv
// Shared types and constants for the lipsi pin-level host bridge.
package lipsi_pin_host_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 16;

    // Bit positions on the design's bidirectional pins
    localparam int unsigned STB_BIT = 0;
    localparam int unsigned RD_BIT  = 1;
    localparam int unsigned ACK_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ASSERT,
        ST_RELEASE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/lipsi_pin_host_if.sv
// Host-side request/response handshake of the lipsi pin host.
interface lipsi_pin_host_if;
    import lipsi_pin_host_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;

    modport master (
        output req_valid, req_write, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  req_valid, req_write, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_timeout
    );
endinterface

// File: rtl/lipsi_sync2.sv
// Two-flop synchroniser with synchronous reset to 0.
// Only built when LIPSI_PIN_SYNC_EN is defined (its sole user is then present).
`ifdef LIPSI_PIN_SYNC_EN
module lipsi_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule
`endif

// File: rtl/lipsi_pin_host.sv
// Pin-level host: turns byte read/write requests into a STB/RD + ACK
// four-phase handshake on the design's ui/uio pins, with per-phase timeout.
// Build option: LIPSI_PIN_SYNC_EN adds a two-flop synchroniser on ACK/uo_out.
module lipsi_pin_host
    import lipsi_pin_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SETUP_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    lipsi_pin_host_if.slave   host,
    output logic [DATA_W-1:0] ui_in,
    output logic [DATA_W-1:0] uio_in,
    input  logic [DATA_W-1:0] uo_out,
    input  logic [DATA_W-1:0] uio_out,
    input  logic [DATA_W-1:0] uio_oe
);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] ui_q;
    logic              stb_q;
    logic              rd_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_timeout_q;

    logic              ack_raw;
    logic              ack_s;
    logic [DATA_W-1:0] uo_s;
    logic              wait_expired;
    logic              unused_pins;

    // ACK only counts while the design actually drives that pin
    assign ack_raw     = uio_out[ACK_BIT] & uio_oe[ACK_BIT];
    assign unused_pins = &{1'b0, uio_out, uio_oe};

`ifdef LIPSI_PIN_SYNC_EN
    logic [DATA_W:0] sync_out;

    lipsi_sync2 #(.WIDTH(DATA_W + 1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({uo_out, ack_raw}),
        .q_o   (sync_out)
    );

    assign ack_s = sync_out[0];
    assign uo_s  = sync_out[DATA_W:1];
`else
    assign ack_s = ack_raw;
    assign uo_s  = uo_out;
`endif

    assign wait_expired = (cnt_q == WAIT_LAST);

    // Transaction sequencer with registered pin and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            rdata_q       <= '0;
            ui_q          <= '0;
            stb_q         <= 1'b0;
            rd_q          <= 1'b0;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (host.req_valid && ready_q) begin
                        write_q <= host.req_write;
                        ui_q    <= host.req_write ? host.req_data : '0;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        stb_q   <= write_q;
                        rd_q    <= ~write_q;
                        state_q <= ST_ASSERT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (ack_s) begin
                        if (!write_q) begin
                            rdata_q <= uo_s;
                        end
                        stb_q   <= 1'b0;
                        rd_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end else if (wait_expired) begin
                        stb_q         <= 1'b0;
                        rd_q          <= 1'b0;
                        cnt_q         <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        cnt_q         <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_data_q    <= rdata_q;
                        state_q       <= ST_RESP;
                    end else if (wait_expired) begin
                        cnt_q         <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_q   <= 1'b0;
                    rsp_timeout_q <= 1'b0;
                    rsp_data_q    <= '0;
                    ui_q          <= '0;
                    ready_q       <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe pins; all other uio_in bits stay low
    always_comb begin
        uio_in          = '0;
        uio_in[STB_BIT] = stb_q;
        uio_in[RD_BIT]  = rd_q;
    end

    assign ui_in            = ui_q;
    assign host.req_ready   = ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_data    = rsp_data_q;
    assign host.rsp_timeout = rsp_timeout_q;
endmodule

// File: doc/lipsi_pin_host.md
LIPSI_PIN_HOST -- requirements
Module: lipsi_pin_host

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for each ACK edge before aborting.
REQ-002 The block SHALL have parameter SETUP_CYCLES, default 1: cycles data/ui_in is held stable before the strobe rises (legal 1..15).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_write  input  1  1 = write byte to the design, 0 = read byte.
REQ-008 req_data  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle response pulse.
REQ-010 rsp_data  output  8  read data; 0 for writes and timeouts.
REQ-011 rsp_timeout  output  1  qualifies rsp_valid: transaction aborted.
REQ-012 ui_in  output  8  drives the design's dedicated inputs.
REQ-013 uio_in  output  8  drives the design's bidirectional input path; bit0 = STB (write strobe), bit1 = RD (read strobe), bits 7:2 = 0.
REQ-014 uo_out  input  8  the design's dedicated outputs; read data source.
REQ-015 uio_out  input  8  the design's bidirectional output path; bit2 = ACK.
REQ-016 uio_oe  input  8  the design's output enables; ACK is valid only when uio_oe[2] = 1, otherwise treated as 0.

Function
REQ-017 The block SHALL implement states IDLE, SETUP, ASSERT, RELEASE, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1, latching req_write and req_data, and moving to SETUP.
REQ-019 In SETUP, ui_in SHALL hold the latched data for writes (0 for reads) with STB and RD at 0, for exactly SETUP_CYCLES cycles, then move to ASSERT.
REQ-020 In ASSERT, STB (write) or RD (read) SHALL be 1 and ui_in SHALL stay stable; on sampled ACK = 1 the block SHALL capture uo_out (reads) and move to RELEASE.
REQ-021 In RELEASE, STB and RD SHALL be 0; on sampled ACK = 0 the block SHALL move to RESP.
REQ-022 RESP SHALL last one cycle, assert rsp_valid with rsp_timeout = 0, and return to IDLE; ui_in returns to 0 in IDLE.
REQ-023 A wait counter SHALL clear on entry to ASSERT and RELEASE; if it reaches TIMEOUT_CYCLES before the awaited ACK level, the block SHALL drop STB/RD, go to RESP with rsp_timeout = 1 and rsp_data = 0.
REQ-024 ACK already 1 on entry to ASSERT SHALL complete the phase on the first sample; ACK already 0 on entry to RELEASE likewise.
REQ-025 rsp_valid SHALL have no backpressure; a new request SHALL be accepted at the earliest in the cycle after RESP.
REQ-026 STB and RD SHALL never be 1 simultaneously.

Reset
REQ-027 Reset SHALL force IDLE, counters 0, ui_in = 0, uio_in = 0, rsp_valid = 0, rsp_data = 0, rsp_timeout = 0; req_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-transaction SHALL abort it without any rsp_valid pulse and drop STB/RD in the same edge.

Configuration
REQ-029 With LIPSI_PIN_SYNC_EN defined, ACK and uo_out SHALL pass through a two-flop synchronizer (two cycles added to each ACK detection); without it they SHALL be sampled directly (detection on the next edge).

Structure
REQ-030 Package lipsi_pin_host_pkg SHALL hold the state enum, the STB/RD/ACK bit-index constants and the wait-counter width.
REQ-031 Sub-module lipsi_sync2 (parameterised-width two-flop synchroniser, synchronous reset to 0) SHALL be instantiated only when LIPSI_PIN_SYNC_EN is defined.

Verification
REQ-032 Write 0xA5, responder raises ACK 3 cycles after STB and drops it 2 cycles after STB falls -> ui_in = 0xA5 stable from SETUP through ASSERT, one rsp_valid, rsp_timeout = 0.
REQ-033 Read with responder driving uo_out = 0x3C and ACK -> rsp_valid with rsp_data = 0x3C, RD never overlaps STB.
REQ-034 ACK never rises, TIMEOUT_CYCLES = 8 -> STB drops after 8 ASSERT cycles, rsp_valid with rsp_timeout = 1, rsp_data = 0.
REQ-035 uio_oe[2] = 0 while uio_out[2] = 1 -> ACK ignored, transaction times out.
REQ-036 Reset pulsed during RELEASE -> no rsp_valid, uio_in = 0 next cycle, req_ready = 1 after reset deasserts.
REQ-037 Back-to-back requests with req_valid held high -> second accepted the cycle after RESP; both responses correct, with and without LIPSI_PIN_SYNC_EN.
